// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - legal parameter ranges and default reset value for d_flip_flop
package dff_pkg;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;

  localparam logic [WIDTH_MAX-1:0] RESET_VALUE_DEFAULT = '0;

endpackage

// File: rtl/d_flip_flop_if.sv
// rtl/d_flip_flop_if.sv - data in / registered data out bundle for d_flip_flop
interface d_flip_flop_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;

  modport master (
    output d,
    input  q,
    input  q_n
  );

  modport slave (
    input  d,
    output q,
    output q_n
  );

endinterface

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one WIDTH-bit register with asynchronous active-low reset
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = RESET_VALUE_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - STAGES-deep D register chain with complemented output
module d_flip_flop
  import dff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = RESET_VALUE_DEFAULT[WIDTH-1:0]
) (
  input  logic          clk,
  input  logic          rst_n,
  d_flip_flop_if.slave  bus
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "d_flip_flop: WIDTH out of range");
  end

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "d_flip_flop: STAGES out of range");
  end

  // w_chain[0] is the input; w_chain[k+1] is the output of stage k
  logic [WIDTH-1:0] w_chain [STAGES+1];

  assign w_chain[0] = bus.d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_chain[k]),
      .o_q   (w_chain[k+1])
    );
  end

  assign bus.q   = w_chain[STAGES];
  assign bus.q_n = ~w_chain[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - directed-vector bench for default and 8-bit/3-stage d_flip_flop
module tb_d_flip_flop;

  logic clk;
  logic rst_n;
  logic rst_n8;

  int n_cmp;
  int n_err;

  d_flip_flop_if #(.WIDTH(1)) u_if1 ();
  d_flip_flop_if #(.WIDTH(8)) u_if8 ();

  d_flip_flop u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1.slave)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (u_if8.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [5:0] vec;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    vec      = 6'b011010;
    rst_n    = 1'b0;
    rst_n8   = 1'b0;
    u_if1.d  = 1'b1;
    u_if8.d  = 8'h3C;

    // reset held with d=1 and the clock running: no capture
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_q", 64'(u_if1.q), 64'd0);
      check("rst_qn", 64'(u_if1.q_n), 64'd1);
    end
    check("w8_rst_q", 64'(u_if8.q), 64'hA5);
    check("w8_rst_qn", 64'(u_if8.q_n), 64'h5A);

    // release away from an edge, then walk d = 0,1,0,1,1,0 (vec LSB first)
    rst_n   = 1'b1;
    u_if1.d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      u_if1.d = vec[i];
      @(posedge clk);
      #1;
      check($sformatf("seq_q%0d", i), 64'(u_if1.q), 64'(vec[i]));
      check($sformatf("seq_qn%0d", i), 64'(u_if1.q_n), 64'(!vec[i]));
      #6 u_if1.d = ~vec[i];
      #2 check($sformatf("seq_hold%0d", i), 64'(u_if1.q), 64'(vec[i]));
    end

    // d pulses 0->1->0 between edges
    @(negedge clk);
    u_if1.d = 1'b0;
    @(posedge clk);
    #1 check("mid_q0", 64'(u_if1.q), 64'd0);
    #2 u_if1.d = 1'b1;
    #2 u_if1.d = 1'b0;
    #4 check("mid_hold", 64'(u_if1.q), 64'd0);
    @(posedge clk);
    #1 check("mid_next", 64'(u_if1.q), 64'd0);

    // asynchronous reset in the middle of a cycle
    @(negedge clk);
    u_if1.d = 1'b1;
    @(posedge clk);
    #1 check("async_pre", 64'(u_if1.q), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_q", 64'(u_if1.q), 64'd0);
    check("async_qn", 64'(u_if1.q_n), 64'd1);
    @(posedge clk);
    #1 check("async_edge", 64'(u_if1.q), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("async_rel", 64'(u_if1.q), 64'd1);

    // release lands on the rising edge itself; the flop must still see reset
    @(negedge clk);
    rst_n   = 1'b0;
    u_if1.d = 1'b1;
    @(posedge clk);
    rst_n <= 1'b1;
    #1 check("coinc_edge", 64'(u_if1.q), 64'd0);
    @(posedge clk);
    #1 check("coinc_next", 64'(u_if1.q), 64'd1);

    // 8-bit, 3-stage: 3C presented before edge n appears after edge n+2
    @(negedge clk);
    rst_n8  = 1'b1;
    u_if8.d = 8'h3C;
    @(posedge clk);
    #1 check("w8_n0", 64'(u_if8.q), 64'hA5);
    u_if8.d = 8'h00;
    @(posedge clk);
    #1 check("w8_n1", 64'(u_if8.q), 64'hA5);
    @(posedge clk);
    #1 check("w8_n2_q", 64'(u_if8.q), 64'h3C);
    check("w8_n2_qn", 64'(u_if8.q_n), 64'hC3);
    @(posedge clk);
    #1 check("w8_n3", 64'(u_if8.q), 64'h00);
    #2 rst_n8 = 1'b0;
    #1 check("w8_async", 64'(u_if8.q), 64'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
